// File: rtl/alarma_zonas.sv
// Multi-zone alarm controller: exit delay, per-zone entry/immediate handling,
// and a re-triggerable siren timer. Single clock domain, synchronous reset.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   DESACTIVADA | disarmed; waiting for inicio
//   SALIDA      | exit delay running; all sensors ignored
//   ACTIVADA    | armed and quiet; timer parked at 0
//   ENTRADA     | delayed zone tripped; entry window counting down
//   ALARMA      | siren on; period re-triggers while any enabled zone is hit
module alarma_zonas #(
  parameter int N_ZONAS = 4,
  parameter int CW = 6,
  parameter int T_SALIDA = 20,
  parameter int T_ENTRADA = 10,
  parameter int T_SIRENA = 30,
  parameter logic [N_ZONAS-1:0] ZONAS_INMED = 4'b1110
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [N_ZONAS-1:0] intruso,
  input  logic [N_ZONAS-1:0] habilitar_zona,
  output logic               sirena,
  output logic               armada,
  output logic [2:0]         estado,
  output logic [N_ZONAS-1:0] zona_disparo,
  output logic [CW-1:0]      count
);

  localparam int T_MAX_AB = (T_SALIDA > T_ENTRADA) ? T_SALIDA : T_ENTRADA;
  localparam int T_MAX = (T_MAX_AB > T_SIRENA) ? T_MAX_AB : T_SIRENA;

  generate
    if ((T_MAX - 1) >= (1 << CW)) begin : g_cw_too_small
      $error("alarma_zonas: CW too narrow for the longest timer reload");
    end
  endgenerate

  localparam logic [CW-1:0] LD_SALIDA  = CW'(T_SALIDA - 1);
  localparam logic [CW-1:0] LD_ENTRADA = CW'(T_ENTRADA - 1);
  localparam logic [CW-1:0] LD_SIRENA  = CW'(T_SIRENA - 1);

  typedef enum logic [2:0] {
    DESACTIVADA = 3'd0,
    SALIDA      = 3'd1,
    ACTIVADA    = 3'd2,
    ENTRADA     = 3'd3,
    ALARMA      = 3'd4
  } estado_t;

  estado_t state, state_nx;
  logic [CW-1:0] count_nx, count_dec;
  logic [N_ZONAS-1:0] zona_nx, hit, hit_i, hit_d;
  logic tc, sirena_nx, armada_nx;

  assign hit   = intruso & habilitar_zona;
  assign hit_i = hit & ZONAS_INMED;
  assign hit_d = hit & ~ZONAS_INMED;
  assign tc    = (count == '0);
  // Saturating decrement: the timer parks at zero rather than wrapping.
  assign count_dec = tc ? '0 : count - CW'(1);

  always_comb begin
    state_nx = state;
    count_nx = count;
    zona_nx  = zona_disparo;
    if ((state != DESACTIVADA) && !inicio) begin
      state_nx = DESACTIVADA;
      count_nx = '0;
    end else begin
      case (state)
        DESACTIVADA: begin
          if (inicio) begin
            state_nx = SALIDA;
            count_nx = LD_SALIDA;
            zona_nx  = '0;
          end
        end
        SALIDA: begin
          if (tc) state_nx = ACTIVADA;
          else    count_nx = count_dec;
        end
        ACTIVADA: begin
          if (|hit_i) begin
            state_nx = ALARMA;
            count_nx = LD_SIRENA;
            zona_nx  = zona_disparo | hit;
          end else if (|hit_d) begin
            state_nx = ENTRADA;
            count_nx = LD_ENTRADA;
            zona_nx  = zona_disparo | hit;
          end
        end
        ENTRADA: begin
          zona_nx = zona_disparo | hit;
          if ((|hit_i) || tc) begin
            state_nx = ALARMA;
            count_nx = LD_SIRENA;
          end else begin
            count_nx = count_dec;
          end
        end
        ALARMA: begin
          zona_nx = zona_disparo | hit;
          if (!tc)        count_nx = count_dec;
          else if (|hit)  count_nx = LD_SIRENA;
          else            state_nx = ACTIVADA;
        end
        default: begin
          state_nx = DESACTIVADA;
          count_nx = '0;
        end
      endcase
    end
  end

  assign sirena_nx = (state_nx == ALARMA);
  assign armada_nx = (state_nx == ACTIVADA) || (state_nx == ENTRADA) || (state_nx == ALARMA);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= DESACTIVADA;
      count        <= '0;
      zona_disparo <= '0;
      sirena       <= 1'b0;
      armada       <= 1'b0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      zona_disparo <= zona_nx;
      sirena       <= sirena_nx;
      armada       <= armada_nx;
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_alarma_zonas.sv
// Bench for alarma_zonas: deadline-based reference model checked every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_alarma_zonas;
  localparam int TS = 20;
  localparam int TE = 10;
  localparam int TA = 30;
  localparam logic [3:0] INMED = 4'b1110;

  logic       clock = 1'b0;
  logic       reset;
  logic       inicio;
  logic [3:0] intruso;
  logic [3:0] habilitar_zona;
  logic       sirena;
  logic       armada;
  logic [2:0] estado;
  logic [3:0] zona_disparo;
  logic [5:0] count;

  int tests = 0;
  int fails = 0;

  alarma_zonas dut (
    .clock(clock),
    .reset(reset),
    .inicio(inicio),
    .intruso(intruso),
    .habilitar_zona(habilitar_zona),
    .sirena(sirena),
    .armada(armada),
    .estado(estado),
    .zona_disparo(zona_disparo),
    .count(count)
  );

  always #1 clock = ~clock;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: mode number plus an absolute deadline (edge index at which the
  // running period expires); the timer value is just the distance to it.
  int m_st = 0;
  int m_dl = 0;
  int cyc = 0;
  logic [3:0] m_zona = 4'b0000;
  bit m_valid = 1'b0;

  function automatic int m_count();
    return (m_dl > cyc) ? (m_dl - cyc) : 0;
  endfunction

  always @(posedge clock) begin : model
    logic [3:0] hit, hi, hd;
    int now;
    now = cyc;
    hit = intruso & habilitar_zona;
    hi = hit & INMED;
    hd = hit & ~INMED;
    if (reset) begin
      m_st = 0; m_dl = 0; m_zona = 4'b0000;
    end else if (m_st != 0 && !inicio) begin
      m_st = 0; m_dl = 0;
    end else begin
      case (m_st)
        0: if (inicio) begin m_st = 1; m_dl = now + TS; m_zona = 4'b0000; end
        1: if (m_dl == now) m_st = 2;
        2: begin
          if (hi != 0) begin m_st = 4; m_dl = now + TA; m_zona = m_zona | hit; end
          else if (hd != 0) begin m_st = 3; m_dl = now + TE; m_zona = m_zona | hit; end
        end
        3: begin
          m_zona = m_zona | hit;
          if (hi != 0 || m_dl == now) begin m_st = 4; m_dl = now + TA; end
        end
        default: begin
          m_zona = m_zona | hit;
          if (m_dl == now) begin
            if (hit != 0) m_dl = now + TA;
            else m_st = 2;
          end
        end
      endcase
    end
    cyc = now + 1;
    m_valid = 1'b1;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("m_estado", int'(estado), m_st);
      chk("m_sirena", int'(sirena), int'(m_st == 4));
      chk("m_armada", int'(armada), int'(m_st >= 2));
      chk("m_zona", int'(zona_disparo), int'(m_zona));
      chk("m_count", int'(count), m_count());
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  // Disarm for one cycle, then arm and wait (bounded) for ACTIVADA.
  task automatic rearm(string name);
    int k;
    inicio = 1'b0;
    intruso = 4'b0000;
    tick(1);
    inicio = 1'b1;
    for (k = 1; k <= 25; k++) begin
      tick(1);
      if (estado == 3'd2) break;
    end
    chk(name, k, 21);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, rise, high;
    reset = 1'b1;
    inicio = 1'b0;
    intruso = 4'b0001;
    habilitar_zona = 4'b1111;

    // 1: reset held with a sensor active
    repeat (3) begin
      tick(1);
      chk("t1_estado", int'(estado), 0);
      chk("t1_sirena", int'(sirena), 0);
    end
    reset = 1'b0;
    intruso = 4'b0000;
    tick(1);
    chk("t1_idle", int'(estado), 0);
    chk("t1_armada", int'(armada), 0);

    // 2: arm; sensor pulse during exit delay is ignored
    inicio = 1'b1;
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 1) chk("t2_salida", int'(estado), 1);
      if (k == 2) intruso = 4'b0001;
      if (k == 3) intruso = 4'b0000;
      if (estado == 3'd2) begin first = k; break; end
    end
    chk("t2_arm_latency", first, 21);
    chk("t2_zona", int'(zona_disparo), 0);

    // 3: delayed zone one cycle, then disarm inside the entry window
    intruso = 4'b0001;
    tick(1);
    intruso = 4'b0000;
    chk("t3_entrada", int'(estado), 3);
    tick(5);
    inicio = 1'b0;
    tick(1);
    chk("t3_disarm", int'(estado), 0);
    chk("t3_sirena", int'(sirena), 0);
    chk("t3_zona", int'(zona_disparo), 1);

    // 4: delayed zone held 25 cycles
    rearm("t4_arm");
    chk("t4_zona_clr", int'(zona_disparo), 0);
    intruso = 4'b0001;
    rise = -1; high = 0;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      if (sirena) begin high++; if (rise < 0) rise = k; end
      if (k == 25) intruso = 4'b0000;
    end
    chk("t4_rise", rise, 11);
    chk("t4_high", high, 30);
    chk("t4_end", int'(estado), 2);
    chk("t4_zona", int'(zona_disparo), 1);

    // 5: immediate zone held 45 cycles -> one reload
    rearm("t5_arm");
    intruso = 4'b0100;
    rise = -1; high = 0;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      if (sirena) begin high++; if (rise < 0) rise = k; end
      if (k == 30) chk("t5_count_tc", int'(count), 0);
      if (k == 31) chk("t5_reload", int'(count), 29);
      if (k == 45) intruso = 4'b0000;
    end
    chk("t5_rise", rise, 1);
    chk("t5_high", high, 60);
    chk("t5_end", int'(estado), 2);
    chk("t5_zona", int'(zona_disparo), 4);

    // 6: masking, simultaneous immediate+delayed, reset mid-ALARMA
    rearm("t6_arm");
    habilitar_zona = 4'b1110;
    intruso = 4'b0001;
    repeat (5) begin
      tick(1);
      chk("t6_masked", int'(estado), 2);
    end
    habilitar_zona = 4'b1111;
    intruso = 4'b0011;
    tick(1);
    chk("t6_alarma", int'(estado), 4);
    chk("t6_zona", int'(zona_disparo), 3);
    chk("t6_sirena_on", int'(sirena), 1);
    tick(3);
    reset = 1'b1;
    inicio = 1'b0;
    intruso = 4'b0000;
    tick(1);
    chk("t6_rst_sirena", int'(sirena), 0);
    chk("t6_rst_estado", int'(estado), 0);
    chk("t6_rst_zona", int'(zona_disparo), 0);
    chk("t6_rst_count", int'(count), 0);
    reset = 1'b0;

    // 7: immediate hit cuts the entry window short; disarm keeps the record
    rearm("t7_arm");
    intruso = 4'b0001;
    tick(1);
    intruso = 4'b0000;
    chk("t7_entrada", int'(estado), 3);
    tick(3);
    intruso = 4'b0010;
    tick(1);
    intruso = 4'b0000;
    chk("t7_alarma", int'(estado), 4);
    chk("t7_count", int'(count), 29);
    chk("t7_zona", int'(zona_disparo), 3);
    tick(2);
    inicio = 1'b0;
    tick(1);
    chk("t7_disarm", int'(estado), 0);
    chk("t7_sirena", int'(sirena), 0);
    chk("t7_zona_kept", int'(zona_disparo), 3);
    chk("t7_count0", int'(count), 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
